// File: rtl/score_glyph_plotter.sv
// score_glyph_plotter: rasterises a two-digit 3x5 glyph map onto the VGA plot bus.
// Optional feature: define SCORE_AUTO_REFRESH_EN to redraw whenever map differs from the snapshot.
module score_glyph_plotter #(
   parameter int         X_ORIGIN  = 140,
   parameter int         Y_ORIGIN  = 4,
   parameter int         SCALE     = 2,
   parameter int         DIGIT_GAP = 1,
   parameter logic [2:0] FG_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [29:0] map,
   input  logic        go,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SMAX  = 2'(SCALE - 1);
   localparam int         DSTEP = (3 + DIGIT_GAP) * SCALE;

   state_t      state;
   state_t      state_nx;
   logic [29:0] snap;
   logic        digit;
   logic [2:0]  row;
   logic [1:0]  sy;
   logic [1:0]  col;
   logic [1:0]  sx;
   logic        start;
   logic        last;

   logic [7:0]  px;
   logic [6:0]  py;
   logic [4:0]  bidx;
   logic [2:0]  pcol;

   logic [7:0]  x_d;
   logic [6:0]  y_d;
   logic [2:0]  colour_d;
   logic        plot_d;
   logic        busy_d;
   logic        done_d;

`ifdef SCORE_AUTO_REFRESH_EN
   assign start = go || (map != snap);
`else
   assign start = go;
`endif

   assign last = digit && (row == 3'd4) && (sy == SMAX)
              && (col == 2'd2) && (sx == SMAX);

   // state register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = DRAW;
         DRAW:    if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // pixel position and colour from the scan counters, 9-bit wrap
   always_comb begin
      px   = 8'(9'(X_ORIGIN) + (digit ? 9'(DSTEP) : 9'd0)
                + 9'(col) * 9'(SCALE) + 9'(sx));
      py   = 7'(9'(Y_ORIGIN) + 9'(row) * 9'(SCALE) + 9'(sy));
      bidx = (digit ? 5'd0 : 5'd15) + 5'(row) * 5'd3 + 5'(col);
      pcol = snap[bidx] ? FG_COLOUR : BG_COLOUR;
   end

   // output decode: next register values from the current state
   always_comb begin
      x_d      = x;
      y_d      = y;
      colour_d = colour;
      plot_d   = (state == DRAW);
      busy_d   = (state != IDLE);
      done_d   = (state == DONE);
      if (state == DRAW) begin
         x_d      = px;
         y_d      = py;
         colour_d = pcol;
      end
   end

   // registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         x      <= x_d;
         y      <= y_d;
         colour <= colour_d;
         plot   <= plot_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

   // snapshot capture and nested scan counters (sx innermost)
   always_ff @(posedge clk) begin
      if (!resetn) begin
         snap  <= '0;
         digit <= 1'b0;
         row   <= '0;
         sy    <= '0;
         col   <= '0;
         sx    <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            snap  <= map;
            digit <= 1'b0;
            row   <= '0;
            sy    <= '0;
            col   <= '0;
            sx    <= '0;
         end
      end else if (state == DRAW) begin
         if (sx != SMAX) begin
            sx <= sx + 2'd1;
         end else begin
            sx <= '0;
            if (col != 2'd2) begin
               col <= col + 2'd1;
            end else begin
               col <= '0;
               if (sy != SMAX) begin
                  sy <= sy + 2'd1;
               end else begin
                  sy <= '0;
                  if (row != 3'd4) begin
                     row <= row + 3'd1;
                  end else begin
                     row   <= '0;
                     digit <= ~digit;
                  end
               end
            end
         end
      end
   end

endmodule
